// File: rtl/inst_queue.sv
// inst_queue: circular two-wide instruction queue between fetch and decode.
// Define INST_QUEUE_BYPASS_EN to forward fetch slots straight to decode when the queue is empty.
module inst_queue #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_iq_i,
  input  logic                     stall_decoder_inst0_i,
  input  logic                     fetch_valid_i,
  input  logic                     fetch_inst1_valid_i,
  input  logic [63:0]              fetch_pc0_i,
  input  logic [63:0]              fetch_pc1_i,
  input  logic [31:0]              fetch_inst0_i,
  input  logic [31:0]              fetch_inst1_i,
  output logic                     fetch_ready_o,
  output logic                     inst0_f1_valid_o,
  output logic [63:0]              inst0_f1_pc_o,
  output logic [31:0]              inst0_f1_inst_o,
  output logic                     inst1_f1_valid_o,
  output logic [63:0]              inst1_f1_pc_o,
  output logic [31:0]              inst1_f1_inst_o,
  output logic [$clog2(DEPTH):0]   iq_count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [63:0] pc_mem [DEPTH];
  logic [31:0] inst_mem [DEPTH];
  logic [AW-1:0] head, tail, head1;
  logic [AW:0] count;
  logic enq, byp, v0, v1;
  logic [1:0] enq_n, wr_n, deq_n;
  assign head1 = head + AW'(1);
  assign iq_count_o = count;
  assign fetch_ready_o = count <= (AW+1)'(DEPTH - 2);
  assign enq = fetch_valid_i & fetch_ready_o & ~flush_iq_i & ~rst;
`ifdef INST_QUEUE_BYPASS_EN
  assign byp = enq & (count == '0);
`else
  assign byp = 1'b0;
`endif
  // A bypassed packet that decode takes this cycle never touches storage.
  always_comb begin
    enq_n = enq ? (fetch_inst1_valid_i ? 2'd2 : 2'd1) : 2'd0;
    wr_n = (byp & ~stall_decoder_inst0_i) ? 2'd0 : enq_n;
    v0 = ~rst & ~flush_iq_i & (byp | (count != '0));
    v1 = ~rst & ~flush_iq_i & (byp ? fetch_inst1_valid_i : (count >= (AW+1)'(2)));
    deq_n = (stall_decoder_inst0_i | flush_iq_i | byp) ? 2'd0 : {1'b0, v0} + {1'b0, v1};
    inst0_f1_valid_o = v0;
    inst1_f1_valid_o = v1;
    inst0_f1_pc_o = v0 ? (byp ? fetch_pc0_i : pc_mem[head]) : '0;
    inst0_f1_inst_o = v0 ? (byp ? fetch_inst0_i : inst_mem[head]) : '0;
    inst1_f1_pc_o = v1 ? (byp ? fetch_pc1_i : pc_mem[head1]) : '0;
    inst1_f1_inst_o = v1 ? (byp ? fetch_inst1_i : inst_mem[head1]) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst || flush_iq_i) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (wr_n != 2'd0) begin
        pc_mem[tail] <= fetch_pc0_i;
        inst_mem[tail] <= fetch_inst0_i;
      end
      if (wr_n == 2'd2) begin
        pc_mem[tail + AW'(1)] <= fetch_pc1_i;
        inst_mem[tail + AW'(1)] <= fetch_inst1_i;
      end
      tail <= tail + AW'(wr_n);
      head <= head + AW'(deq_n);
      count <= count + (AW+1)'(wr_n) - (AW+1)'(deq_n);
    end
  end
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed scenarios plus random traffic checked against a queue-based model.
module tb_inst_queue;
  localparam int DEPTH = 8;
  logic clk = 0, rst, flush_iq_i, stall_decoder_inst0_i, fetch_valid_i, fetch_inst1_valid_i;
  logic [63:0] fetch_pc0_i, fetch_pc1_i, inst0_f1_pc_o, inst1_f1_pc_o;
  logic [31:0] fetch_inst0_i, fetch_inst1_i, inst0_f1_inst_o, inst1_f1_inst_o;
  logic fetch_ready_o, inst0_f1_valid_o, inst1_f1_valid_o;
  logic [$clog2(DEPTH):0] iq_count_o;
  int n_chk = 0, n_err = 0;
  logic [95:0] q[$];
  logic [63:0] dq_log[$];

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush_iq_i(flush_iq_i), .stall_decoder_inst0_i(stall_decoder_inst0_i),
    .fetch_valid_i(fetch_valid_i), .fetch_inst1_valid_i(fetch_inst1_valid_i),
    .fetch_pc0_i(fetch_pc0_i), .fetch_pc1_i(fetch_pc1_i),
    .fetch_inst0_i(fetch_inst0_i), .fetch_inst1_i(fetch_inst1_i), .fetch_ready_o(fetch_ready_o),
    .inst0_f1_valid_o(inst0_f1_valid_o), .inst0_f1_pc_o(inst0_f1_pc_o), .inst0_f1_inst_o(inst0_f1_inst_o),
    .inst1_f1_valid_o(inst1_f1_valid_o), .inst1_f1_pc_o(inst1_f1_pc_o), .inst1_f1_inst_o(inst1_f1_inst_o),
    .iq_count_o(iq_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check against the model, then advance the model at posedge.
  task automatic cyc(input bit r, input bit fl, input bit st, input bit fv, input bit f1,
                     input logic [63:0] p0, input logic [63:0] p1);
    logic [31:0] i0, i1;
    logic [95:0] e0, e1;
    bit en, byp, ev0, ev1;
    int n;
    i0 = $urandom;
    i1 = $urandom;
    rst = r; flush_iq_i = fl; stall_decoder_inst0_i = st; fetch_valid_i = fv;
    fetch_inst1_valid_i = f1; fetch_pc0_i = p0; fetch_pc1_i = p1;
    fetch_inst0_i = i0; fetch_inst1_i = i1;
    #2;
    en = fv && q.size() <= DEPTH - 2 && !fl && !r;
    byp = 0;
`ifdef INST_QUEUE_BYPASS_EN
    byp = en && q.size() == 0;
`endif
    ev0 = !r && !fl && (byp || q.size() >= 1);
    ev1 = !r && !fl && (byp ? f1 : q.size() >= 2);
    e0 = !ev0 ? '0 : byp ? {p0, i0} : q[0];
    e1 = !ev1 ? '0 : byp ? {p1, i1} : q[1];
    chk("ready", fetch_ready_o, q.size() <= DEPTH - 2);
    chk("count", iq_count_o, q.size());
    chk("v0", inst0_f1_valid_o, ev0);
    chk("v1", inst1_f1_valid_o, ev1);
    chk("slot0", {inst0_f1_pc_o, inst0_f1_inst_o}, e0);
    chk("slot1", {inst1_f1_pc_o, inst1_f1_inst_o}, e1);
    if (!st && inst0_f1_valid_o) dq_log.push_back(inst0_f1_pc_o);
    if (!st && inst1_f1_valid_o) dq_log.push_back(inst1_f1_pc_o);
    @(posedge clk);
    if (r || fl) q.delete();
    else if (byp) begin
      if (st) begin
        q.push_back({p0, i0});
        if (f1) q.push_back({p1, i1});
      end
    end else begin
      n = st ? 0 : int'(ev0) + int'(ev1);
      repeat (n) void'(q.pop_front());
      if (en) begin
        q.push_back({p0, i0});
        if (f1) q.push_back({p1, i1});
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] pc;
    @(negedge clk);
    // Reset held two cycles with fetch traffic present.
    cyc(1, 0, 0, 1, 1, 64'h100, 64'h104);
    cyc(1, 0, 0, 1, 1, 64'h108, 64'h10c);
    chk("rst_cnt", iq_count_o, 0);
    chk("rst_rdy", fetch_ready_o, 1);
    cyc(0, 0, 1, 0, 0, 0, 0);
    // Fill with stall held; fifth packet must be dropped.
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, 1, 64'h200 + 8 * i, 64'h204 + 8 * i);
    chk("full_cnt", iq_count_o, 8);
    chk("full_rdy", fetch_ready_o, 0);
    repeat (5) cyc(0, 0, 0, 0, 0, 0, 0);
    chk("drain_cnt", iq_count_o, 0);
    // Single odd entry.
    cyc(0, 0, 1, 1, 0, 64'h1000, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("odd_cnt", iq_count_o, 0);
    // Wrap-around with stall toggling every cycle.
    dq_log.delete();
    for (int i = 0; i < 20; i++) cyc(0, 0, i[0], 1, 0, 64'(4 * i), 0);
    repeat (12) cyc(0, 0, 0, 0, 0, 0, 0);
    chk("wrap_n", dq_log.size(), 20);
    for (int i = 0; i < dq_log.size(); i++) chk("wrap_pc", dq_log[i], 64'(4 * i));
    // Flush with occupancy 5 and a concurrent packet.
    cyc(0, 0, 1, 1, 1, 64'h300, 64'h304);
    cyc(0, 0, 1, 1, 1, 64'h308, 64'h30c);
    cyc(0, 0, 1, 1, 0, 64'h310, 0);
    chk("pre_flush", iq_count_o, 5);
    cyc(0, 1, 0, 1, 1, 64'h400, 64'h404);
    chk("flush_cnt", iq_count_o, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    // Bypass candidate from empty.
    cyc(0, 0, 0, 1, 0, 64'h8000_0000, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("byp_cnt", iq_count_o, 0);
    // Random traffic.
    pc = 64'h1_0000;
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, pc, pc + 4);
      pc += 8;
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
